// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: per-register stall/flush, PC enable, dmem wait-state
// tracking with timeout, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memread_EX,
  input  logic             redirect_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ack_MEM,
  output logic             pc_en,
  output logic             stall_IF,
  output logic             flush_IF,
  output logic             stall_ID,
  output logic             flush_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] Timeout = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, memwait, stall_ev, flush_ev;

  assign load_use = memread_EX && (rd_EX != 5'd0) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));

  // An ack in MEM_WAIT releases the stall in the same cycle.
  assign memwait = ((state_q == StRun) && mem_req_MEM && !mem_ack_MEM) ||
                   ((state_q == StMemWait) && !mem_ack_MEM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StRun: begin
        if (mem_req_MEM && !mem_ack_MEM) begin
          state_d = StMemWait;
          wait_d  = 8'd1;
        end
      end
      StMemWait: begin
        if (mem_ack_MEM) begin
          state_d = StRun;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == Timeout) state_d = StErr;
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc_en     = 1'b0;
    stall_IF  = 1'b0;
    flush_IF  = 1'b0;
    stall_ID  = 1'b0;
    flush_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    if (rst_i) begin
      flush_IF = 1'b1;
      flush_ID = 1'b1;
    end else if (state_q == StErr || memwait) begin
      stall_IF  = 1'b1;
      stall_ID  = 1'b1;
      stall_EX  = 1'b1;
      stall_MEM = 1'b1;
    end else if (redirect_EX) begin
      pc_en    = 1'b1;
      flush_IF = 1'b1;
      flush_ID = 1'b1;
    end else if (load_use) begin
      stall_IF = 1'b1;
      flush_ID = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  assign err_o    = (state_q == StErr);
  assign stall_ev = !rst_i && (state_q != StErr) && !pc_en;
  assign flush_ev = !rst_i && flush_IF;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ev && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations are queued when a step is driven
// and popped/compared mid-cycle against the DUT outputs.
module tb_hazard_ctrl;

  localparam int unsigned CntW = 4;

  // {pc_en, stall_IF, flush_IF, stall_ID, flush_ID, stall_EX, stall_MEM}
  localparam logic [6:0] CIdle = 7'b1000000;
  localparam logic [6:0] CLu   = 7'b0100100;
  localparam logic [6:0] CRd   = 7'b1010100;
  localparam logic [6:0] CFs   = 7'b0101011;
  localparam logic [6:0] CRst  = 7'b0010100;

  typedef struct packed {
    logic [6:0]      ctrl;
    logic            err;
    logic [CntW-1:0] sc;
    logic [CntW-1:0] fc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [4:0]      rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
  logic            rs1_used_ID = 1'b0, rs2_used_ID = 1'b0;
  logic            memread_EX = 1'b0, redirect_EX = 1'b0;
  logic            mem_req_MEM = 1'b0, mem_ack_MEM = 1'b0;
  logic            pc_en, stall_IF, flush_IF, stall_ID, flush_ID, stall_EX, stall_MEM, err_o;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  exp_t            sb[$];
  logic [CntW-1:0] m_stall = '0, m_flush = '0;
  int              checks = 0, errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CntW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .rs1_used_ID(rs1_used_ID),
    .rs2_used_ID(rs2_used_ID),
    .rd_EX      (rd_EX),
    .memread_EX (memread_EX),
    .redirect_EX(redirect_EX),
    .mem_req_MEM(mem_req_MEM),
    .mem_ack_MEM(mem_ack_MEM),
    .pc_en      (pc_en),
    .stall_IF   (stall_IF),
    .flush_IF   (flush_IF),
    .stall_ID   (stall_ID),
    .flush_ID   (flush_ID),
    .stall_EX   (stall_EX),
    .stall_MEM  (stall_MEM),
    .err_o      (err_o),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  task automatic step(input string tag, input logic rst, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic rdr, input logic req, input logic ack,
                      input logic [6:0] ctrl, input logic err);
    exp_t       e;
    logic [6:0] obs;
    rst_i = rst; rs1_ID = rs1; rs1_used_ID = u1; rs2_ID = rs2; rs2_used_ID = u2;
    rd_EX = rd; memread_EX = mr; redirect_EX = rdr; mem_req_MEM = req; mem_ack_MEM = ack;
    sb.push_back('{ctrl: ctrl, err: err, sc: m_stall, fc: m_flush});
    // Reference counter model: stalls exclude ERR, both exclude reset, both saturate.
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!ctrl[6] && !err && m_stall != '1) m_stall = m_stall + 1'b1;
      if (ctrl[4] && m_flush != '1) m_flush = m_flush + 1'b1;
    end
    @(negedge clk);
    e   = sb.pop_front();
    obs = {pc_en, stall_IF, flush_IF, stall_ID, flush_ID, stall_EX, stall_MEM};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++; $error("FAIL %s ctrl got=%b exp=%b", tag, obs, e.ctrl);
    end
    checks++;
    assert (err_o === e.err) else begin
      errors++; $error("FAIL %s err_o got=%b exp=%b", tag, err_o, e.err);
    end
    checks++;
    assert (stall_cnt === e.sc) else begin
      errors++; $error("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, e.sc);
    end
    checks++;
    assert (flush_cnt === e.fc) else begin
      errors++; $error("FAIL %s flush_cnt got=%0d exp=%0d", tag, flush_cnt, e.fc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //   tag          rst rs1 u1 rs2 u2 rd  mr rdr req ack ctrl   err
    step("reset",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CRst,  0);
    step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    step("lu_rs2",    0, 0, 0, 5, 1, 5, 1, 0, 0, 0, CLu,   0);
    step("after_lu",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    step("lu_rd0",    0, 0, 1, 0, 0, 0, 1, 0, 0, 0, CIdle, 0);
    step("lu_unused", 0, 7, 0, 7, 0, 7, 1, 0, 0, 0, CIdle, 0);
    step("no_load",   0, 9, 1, 0, 0, 9, 0, 0, 0, 0, CIdle, 0);
    step("rdr_lu",    0, 5, 1, 0, 0, 5, 1, 1, 0, 0, CRd,   0);
    step("after_rdr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    step("mw_run",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    step("mw_1",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    step("mw_2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    step("mw_ack",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, CIdle, 0);
    step("mw_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    step("mw2_run",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    step("ack_lu",    0, 3, 1, 0, 0, 3, 1, 0, 1, 1, CLu,   0);
    step("ack_lu_nx", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    step("req_ack",   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, CIdle, 0);
    step("req_ack_nx",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    step("mwr_run",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    step("mwr_1",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    step("mwr_rst",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, CRst,  0);
    step("mwr_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    step("to_run",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    for (int i = 1; i <= 4; i++) begin
      step("to_wait",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CFs,   0);
    end
    step("err_enter", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, CFs,   1);
    step("err_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CFs,   1);
    step("err_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CRst,  1);
    step("post_err",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    for (int i = 0; i < 17; i++) begin
      step("sat_stall", 0, 6, 1, 0, 0, 6, 1, 0, 0, 0, CLu,   0);
    end
    for (int i = 0; i < 17; i++) begin
      step("sat_flush", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CRd,   0);
    end
    step("sat_check", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CIdle, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
